// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
//   Shares the single register-file write port between two write-back
//   requesters (req0 = ALU, req1 = load unit) using round-robin arbitration
//   with valid/ready handshakes. An accepted write is issued to the register
//   file one cycle later through registered RegWrite/WriteReg/WriteData.
//   A per-register pending scoreboard lets decode detect RAW hazards on
//   ReadReg1/ReadReg2 until the outstanding write has committed.
//
// Ports
//   clk, reset               clock, synchronous active-high reset
//   req0_* / req1_*          write-back requests (valid, reg, data) and ready
//   rsv_valid, rsv_reg       decode reservation of a destination register
//   ReadReg1/2, hazard1/2    hazard queries against the pending scoreboard
//   RegWrite, WriteReg,
//   WriteData, grant_id      registered register-file write port and source
//   idle                     nothing pending and no write in flight
module regfile_write_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_reg,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_reg,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    input  logic              rsv_valid,
    input  logic [ADDR_W-1:0] rsv_reg,
    input  logic [ADDR_W-1:0] ReadReg1,
    input  logic [ADDR_W-1:0] ReadReg2,
    output logic              hazard1,
    output logic              hazard2,
    output logic              RegWrite,
    output logic [ADDR_W-1:0] WriteReg,
    output logic [DATA_W-1:0] WriteData,
    output logic              grant_id,
    output logic              idle
);

    localparam int NREG = 2 ** ADDR_W;

    logic              lastGrant;
    logic [NREG-1:0]   pending;
    logic [NREG-1:0]   pendingNext;
    logic              grant0;
    logic              grant1;
    logic              hs0;
    logic              hs1;
    logic              hsAny;
    logic [ADDR_W-1:0] hsReg;
    logic [DATA_W-1:0] hsData;

    // Round-robin: on contention the requester that did not win last time
    // is granted; a lone requester is always granted.
    always_comb begin
        grant0 = req0_valid & (~req1_valid | lastGrant);
        grant1 = req1_valid & (~req0_valid | ~lastGrant);
    end

    assign req0_ready = grant0 & ~reset;
    assign req1_ready = grant1 & ~reset;

    always_comb begin
        hs0    = req0_valid & req0_ready;
        hs1    = req1_valid & req1_ready;
        hsAny  = hs0 | hs1;
        hsReg  = hs1 ? req1_reg : req0_reg;
        hsData = hs1 ? req1_data : req0_data;
    end

    // Clear for the committing write is applied first so that a reservation
    // of the same register on the same edge survives (newer reservation).
    always_comb begin
        pendingNext = pending;
        if (RegWrite) begin
            pendingNext[WriteReg] = 1'b0;
        end
        if (rsv_valid && rsv_reg != '0) begin
            pendingNext[rsv_reg] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            RegWrite  <= 1'b0;
            WriteReg  <= '0;
            WriteData <= '0;
            grant_id  <= 1'b0;
            pending   <= '0;
            lastGrant <= 1'b1;
        end else begin
            pending <= pendingNext;
            // Writes to register 0 are accepted and silently consumed.
            RegWrite <= hsAny && (hsReg != '0);
            if (hsAny) begin
                lastGrant <= hs1;
            end
            if (hsAny && hsReg != '0) begin
                WriteReg  <= hsReg;
                WriteData <= hsData;
                grant_id  <= hs1;
            end
        end
    end

    // pending[0] is never set, so register 0 never reports a hazard.
    assign hazard1 = pending[ReadReg1];
    assign hazard2 = pending[ReadReg2];
    assign idle    = (pending == '0) & ~RegWrite;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter
//   Directed testbench for regfile_write_arbiter. Inputs are driven just
//   after the rising edge; outputs are sampled 1 time unit later
//   (combinational) or after the next rising edge (registered).
module tb_regfile_write_arbiter;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    logic              clk = 1'b0;
    logic              reset;
    logic              req0_valid;
    logic [ADDR_W-1:0] req0_reg;
    logic [DATA_W-1:0] req0_data;
    logic              req0_ready;
    logic              req1_valid;
    logic [ADDR_W-1:0] req1_reg;
    logic [DATA_W-1:0] req1_data;
    logic              req1_ready;
    logic              rsv_valid;
    logic [ADDR_W-1:0] rsv_reg;
    logic [ADDR_W-1:0] ReadReg1;
    logic [ADDR_W-1:0] ReadReg2;
    logic              hazard1;
    logic              hazard2;
    logic              RegWrite;
    logic [ADDR_W-1:0] WriteReg;
    logic [DATA_W-1:0] WriteData;
    logic              grant_id;
    logic              idle;

    int nTests = 0;
    int nFail  = 0;

    always #5 clk = ~clk;

    regfile_write_arbiter #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req0_valid(req0_valid),
        .req0_reg  (req0_reg),
        .req0_data (req0_data),
        .req0_ready(req0_ready),
        .req1_valid(req1_valid),
        .req1_reg  (req1_reg),
        .req1_data (req1_data),
        .req1_ready(req1_ready),
        .rsv_valid (rsv_valid),
        .rsv_reg   (rsv_reg),
        .ReadReg1  (ReadReg1),
        .ReadReg2  (ReadReg2),
        .hazard1   (hazard1),
        .hazard2   (hazard2),
        .RegWrite  (RegWrite),
        .WriteReg  (WriteReg),
        .WriteData (WriteData),
        .grant_id  (grant_id),
        .idle      (idle)
    );

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nTests++;
        if (got !== exp) begin
            nFail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset      = 1'b1;
        req0_valid = 1'b1;
        req0_reg   = 5'd1;
        req0_data  = '0;
        req1_valid = 1'b1;
        req1_reg   = 5'd2;
        req1_data  = '0;
        rsv_valid  = 1'b0;
        rsv_reg    = '0;
        ReadReg1   = '0;
        ReadReg2   = '0;

        // Reset state; requests present while reset is high are never accepted.
        nextCycle();
        nextCycle();
        checkVal("rst_ready0", 32'(req0_ready), 32'd0);
        checkVal("rst_ready1", 32'(req1_ready), 32'd0);
        checkVal("rst_RegWrite", 32'(RegWrite), 32'd0);
        checkVal("rst_WriteReg", 32'(WriteReg), 32'd0);
        checkVal("rst_WriteData", WriteData, 32'd0);
        checkVal("rst_grant_id", 32'(grant_id), 32'd0);
        checkVal("rst_idle", 32'(idle), 32'd1);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        nextCycle();

        // Single ALU write, latency 1.
        reset      = 1'b0;
        req0_valid = 1'b1;
        req0_reg   = 5'd1;
        req0_data  = 32'h12345678;
        #1;
        checkVal("t1_ready0", 32'(req0_ready), 32'd1);
        nextCycle();
        req0_valid = 1'b0;
        checkVal("t1_RegWrite", 32'(RegWrite), 32'd1);
        checkVal("t1_WriteReg", 32'(WriteReg), 32'd1);
        checkVal("t1_WriteData", WriteData, 32'h12345678);
        checkVal("t1_grant_id", 32'(grant_id), 32'd0);

        // Lone load write (reg 2) so the last winner is req1.
        req1_valid = 1'b1;
        req1_reg   = 5'd2;
        req1_data  = 32'h0000_0222;
        #1;
        checkVal("t2_ready1", 32'(req1_ready), 32'd1);
        nextCycle();
        req1_valid = 1'b0;
        checkVal("t2_grant_id", 32'(grant_id), 32'd1);
        checkVal("t2_WriteData", WriteData, 32'h0000_0222);

        // Contention for 4 cycles: grants alternate 0,1,0,1.
        req0_valid = 1'b1;
        req0_reg   = 5'd3;
        req0_data  = 32'haaaa_0003;
        req1_valid = 1'b1;
        req1_reg   = 5'd4;
        req1_data  = 32'hbbbb_0004;
        for (int k = 0; k < 4; k++) begin
            #1;
            checkVal($sformatf("rr%0d_ready0", k), 32'(req0_ready), (k % 2 == 0) ? 32'd1 : 32'd0);
            checkVal($sformatf("rr%0d_ready1", k), 32'(req1_ready), (k % 2 == 0) ? 32'd0 : 32'd1);
            nextCycle();
            checkVal($sformatf("rr%0d_RegWrite", k), 32'(RegWrite), 32'd1);
            checkVal($sformatf("rr%0d_grant_id", k), 32'(grant_id), 32'(k % 2));
            checkVal($sformatf("rr%0d_WriteReg", k), 32'(WriteReg), (k % 2 == 0) ? 32'd3 : 32'd4);
            checkVal($sformatf("rr%0d_WriteData", k), WriteData,
                     (k % 2 == 0) ? 32'haaaa_0003 : 32'hbbbb_0004);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        nextCycle();
        checkVal("rr_end_RegWrite", 32'(RegWrite), 32'd0);
        checkVal("rr_end_WriteReg_hold", 32'(WriteReg), 32'd4);
        checkVal("rr_end_WriteData_hold", WriteData, 32'hbbbb_0004);
        checkVal("rr_end_idle", 32'(idle), 32'd1);

        // Reserve reg 5, then the load unit writes it.
        rsv_valid = 1'b1;
        rsv_reg   = 5'd5;
        ReadReg1  = 5'd5;
        #1;
        checkVal("t3_hazard1_before", 32'(hazard1), 32'd0);
        nextCycle();
        rsv_valid = 1'b0;
        checkVal("t3_hazard1_set", 32'(hazard1), 32'd1);
        checkVal("t3_idle_busy", 32'(idle), 32'd0);
        req1_valid = 1'b1;
        req1_reg   = 5'd5;
        req1_data  = 32'h87654321;
        #1;
        checkVal("t3_ready1", 32'(req1_ready), 32'd1);
        nextCycle();
        req1_valid = 1'b0;
        checkVal("t3_RegWrite", 32'(RegWrite), 32'd1);
        checkVal("t3_hazard1_during", 32'(hazard1), 32'd1);
        nextCycle();
        checkVal("t3_hazard1_after", 32'(hazard1), 32'd0);
        checkVal("t3_idle", 32'(idle), 32'd1);

        // Same-edge reserve and commit of reg 6: the reservation wins.
        rsv_valid = 1'b1;
        rsv_reg   = 5'd6;
        ReadReg2  = 5'd6;
        nextCycle();
        rsv_valid  = 1'b0;
        req0_valid = 1'b1;
        req0_reg   = 5'd6;
        req0_data  = 32'h0000_0666;
        nextCycle();
        req0_valid = 1'b0;
        rsv_valid  = 1'b1;
        checkVal("t4_RegWrite6", 32'(RegWrite), 32'd1);
        checkVal("t4_WriteReg6", 32'(WriteReg), 32'd6);
        nextCycle();
        rsv_valid = 1'b0;
        checkVal("t4_RegWrite_off", 32'(RegWrite), 32'd0);
        checkVal("t4_hazard2_kept", 32'(hazard2), 32'd1);
        // One further write clears the bit (no reservation count).
        req0_valid = 1'b1;
        nextCycle();
        req0_valid = 1'b0;
        checkVal("t4_hazard2_during", 32'(hazard2), 32'd1);
        nextCycle();
        checkVal("t4_hazard2_clear", 32'(hazard2), 32'd0);
        checkVal("t4_idle", 32'(idle), 32'd1);

        // Write and reserve of register 0 are consumed/ignored.
        req1_valid = 1'b1;
        req1_reg   = 5'd0;
        req1_data  = 32'hdeadbeef;
        rsv_valid  = 1'b1;
        rsv_reg    = 5'd0;
        ReadReg1   = 5'd0;
        #1;
        checkVal("t5_ready1", 32'(req1_ready), 32'd1);
        nextCycle();
        req1_valid = 1'b0;
        rsv_valid  = 1'b0;
        checkVal("t5_RegWrite", 32'(RegWrite), 32'd0);
        checkVal("t5_WriteData_hold", WriteData, 32'h0000_0666);
        checkVal("t5_hazard1_r0", 32'(hazard1), 32'd0);
        checkVal("t5_idle", 32'(idle), 32'd1);
        // The reg-0 handshake still counts as req1's turn.
        req0_valid = 1'b1;
        req0_reg   = 5'd8;
        req0_data  = 32'h0000_0888;
        req1_valid = 1'b1;
        req1_reg   = 5'd9;
        req1_data  = 32'h0000_0999;
        #1;
        checkVal("t5_rr_ready0", 32'(req0_ready), 32'd1);
        checkVal("t5_rr_ready1", 32'(req1_ready), 32'd0);
        nextCycle();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        checkVal("t5_rr_grant_id", 32'(grant_id), 32'd0);
        checkVal("t5_rr_WriteReg", 32'(WriteReg), 32'd8);
        nextCycle();

        // Reset in the middle of activity.
        rsv_valid  = 1'b1;
        rsv_reg    = 5'd7;
        ReadReg1   = 5'd7;
        req0_valid = 1'b1;
        req0_reg   = 5'd7;
        req0_data  = 32'h0000_0777;
        nextCycle();
        rsv_valid  = 1'b0;
        req1_valid = 1'b1;
        reset      = 1'b1;
        #1;
        checkVal("t6_rst_ready0", 32'(req0_ready), 32'd0);
        checkVal("t6_rst_ready1", 32'(req1_ready), 32'd0);
        nextCycle();
        checkVal("t6_RegWrite", 32'(RegWrite), 32'd0);
        checkVal("t6_hazard1", 32'(hazard1), 32'd0);
        checkVal("t6_idle", 32'(idle), 32'd1);
        reset = 1'b0;
        #1;
        checkVal("t6_post_ready0", 32'(req0_ready), 32'd1);
        checkVal("t6_post_ready1", 32'(req1_ready), 32'd0);
        nextCycle();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        checkVal("t6_post_grant_id", 32'(grant_id), 32'd0);
        checkVal("t6_post_WriteData", WriteData, 32'h0000_0777);

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
